// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Image layout: 2-byte word count, 4-byte big-endian words, 1 XOR checksum byte.
package mips_loader_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_e;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned CSUM_BYTES     = 1;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into 32-bit big-endian words (first byte lands in bits 31:24).
// The completed word and its valid strobe are registered, one cycle after the 4th byte.
module byte_packer
    import mips_loader_pkg::*;
(
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic        word_last_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

    logic [31:0]      shift_q, shift_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;

    always_comb begin
        word_last_o = shift_i && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
        shift_d     = shift_q;
        idx_d       = idx_q;
        valid_d     = word_last_o;
        if (clear_i) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (shift_i) begin
            shift_d = {shift_q[23:0], byte_i};
            idx_d   = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            shift_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign word_valid_o = valid_q;
    assign word_o       = shift_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: receives a length-prefixed, XOR-checked
// byte image and writes it to consecutive word addresses while holding the core.
module imem_loader
    import mips_loader_pkg::*;
#(
    parameter int unsigned DEPTH_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    input  logic               reload,
    output logic               imem_we,
    output logic [DEPTH_W-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               core_hold,
    output logic               done,
    output logic               error
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << DEPTH_W;

    state_e             state_q, state_d;
    logic [15:0]        count_q, count_d;
    logic [15:0]        word_cnt_q, word_cnt_d;
    logic [7:0]         xor_q, xor_d;
    logic [DEPTH_W-1:0] addr_q, addr_d;

    logic        accept;
    logic        enter_hdr;
    logic        pk_shift;
    logic        pk_last;
    logic        pk_valid;
    logic [31:0] pk_word;
    logic [15:0] n_hdr;

    assign accept    = rx_valid && rx_ready;
    assign enter_hdr = ((state_q == DONE) || (state_q == ERR)) && reload;
    assign pk_shift  = accept && (state_q == DATA);
    assign n_hdr     = {count_q[15:8], rx_data};

    byte_packer u_packer (
        .clock_i      (clock),
        .reset_i      (reset),
        .clear_i      (enter_hdr),
        .shift_i      (pk_shift),
        .byte_i       (rx_data),
        .word_last_o  (pk_last),
        .word_valid_o (pk_valid),
        .word_o       (pk_word)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= HDR_HI;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HDR_HI: if (accept) state_d = HDR_LO;
            HDR_LO: begin
                if (accept) begin
                    if (n_hdr == 16'd0)                   state_d = CSUM;
                    else if ({1'b0, n_hdr} > MAX_WORDS)   state_d = ERR;
                    else                                  state_d = DATA;
                end
            end
            DATA: begin
                if (pk_shift && pk_last && ((word_cnt_q + 16'd1) == count_q)) state_d = CSUM;
            end
            CSUM: if (accept) state_d = (rx_data == xor_q) ? DONE : ERR;
            DONE: if (reload) state_d = HDR_HI;
            ERR:  if (reload) state_d = HDR_HI;
            default: state_d = HDR_HI;
        endcase
    end

    always_comb begin
        rx_ready  = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                    (state_q == DATA)   || (state_q == CSUM);
        done      = (state_q == DONE);
        error     = (state_q == ERR);
        core_hold = (state_q != DONE);
    end

    // The write address is captured with the 4th byte so it lines up with the packer's registered word.
    always_comb begin
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        xor_d      = xor_q;
        addr_d     = addr_q;
        if (enter_hdr) begin
            word_cnt_d = '0;
            xor_d      = '0;
            addr_d     = '0;
        end else if (accept) begin
            if (state_q == HDR_HI) count_d[15:8] = rx_data;
            if (state_q == HDR_LO) count_d[7:0]  = rx_data;
            if (state_q == DATA) begin
                xor_d = xor_q ^ rx_data;
                if (pk_last) begin
                    addr_d     = word_cnt_q[DEPTH_W-1:0];
                    word_cnt_d = word_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            word_cnt_q <= '0;
            xor_q      <= '0;
            addr_q     <= '0;
        end else begin
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            xor_q      <= xor_d;
            addr_q     <= addr_d;
        end
    end

    assign imem_we    = pk_valid;
    assign imem_addr  = addr_q;
    assign imem_wdata = pk_word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized image loads checked against a byte-list reference model.
module tb_imem_loader;

    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          reload = 1'b0;
    logic          rx_ready;
    logic          imem_we;
    logic [DW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_hold;
    logic          done;
    logic          error;

    imem_loader #(.DEPTH_W(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int            acc_q[$];
    int            wr_cyc_q[$];
    logic [DW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    logic [7:0]    img[$];

    always @(negedge clock) begin
        cyc++;
        if (!reset && rx_valid && rx_ready) acc_q.push_back(cyc);
        if (imem_we) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        acc_q.delete();
        wr_cyc_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic make_image(input int n, input logic [31:0] words[$], input bit bad);
        logic [7:0] cs;
        cs = '0;
        img.delete();
        img.push_back(8'((n >> 8) & 255));
        img.push_back(8'(n & 255));
        foreach (words[i]) begin
            for (int b = 3; b >= 0; b--) begin
                img.push_back(8'((words[i] >> (8 * b)) & 32'hFF));
                cs ^= 8'((words[i] >> (8 * b)) & 32'hFF);
            end
        end
        img.push_back(bad ? (cs ^ 8'h01) : cs);
    endtask

    task automatic send(input int stall_pct, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            int guard;
            bit ok;
            guard = 0;
            ok = 1'b0;
            while (!ok && guard < 100) begin
                @(posedge clock); #1;
                rx_data  = img[i];
                rx_valid = ($urandom_range(0, 99) >= stall_pct);
                @(negedge clock);
                ok = rx_valid && rx_ready;
                guard++;
            end
            checks++;
            assert (ok) else begin
                errors++;
                $error("FAIL accept_timeout observed=0 expected=1 byte=%0d", i);
            end
            if (!ok) begin
                rx_valid = 1'b0;
                return;
            end
        end
        @(posedge clock); #1;
        rx_valid = 1'b0;
    endtask

    // Reference: parse the image byte list directly for expected writes and verdict.
    task automatic run_image(input int stall_pct, input string tag);
        int n;
        bit hdr_err;
        bit exp_done;
        logic [7:0] x;
        int nw;
        n = (int'(img[0]) << 8) | int'(img[1]);
        hdr_err = (n > (1 << DW));
        x = '0;
        if (!hdr_err) for (int i = 0; i < 4 * n; i++) x ^= img[2 + i];
        exp_done = !hdr_err && (img[img.size() - 1] == x);
        clear_mon();
        send(stall_pct, img.size());
        check({tag, "_done"},      32'(done),      32'(exp_done));
        check({tag, "_error"},     32'(error),     32'(!exp_done));
        check({tag, "_core_hold"}, 32'(core_hold), 32'(!exp_done));
        check({tag, "_rx_ready"},  32'(rx_ready),  32'd0);
        repeat (2) @(negedge clock);
        nw = hdr_err ? 0 : n;
        check({tag, "_nwrites"}, 32'(wr_cyc_q.size()), 32'(nw));
        for (int i = 0; i < nw && i < wr_cyc_q.size(); i++) begin
            logic [31:0] w;
            w = {img[2 + 4 * i], img[3 + 4 * i], img[4 + 4 * i], img[5 + 4 * i]};
            check({tag, "_addr"}, 32'(wr_addr_q[i]), 32'(i));
            check({tag, "_data"}, wr_data_q[i], w);
            if (5 + 4 * i < acc_q.size())
                check({tag, "_latency"}, 32'(wr_cyc_q[i]), 32'(acc_q[5 + 4 * i] + 1));
        end
    endtask

    task automatic pulse_reload();
        @(posedge clock); #1;
        reload = 1'b1;
        @(posedge clock); #1;
        reload = 1'b0;
        check("reload_rx_ready",  32'(rx_ready),  32'd1);
        check("reload_done",      32'(done),      32'd0);
        check("reload_error",     32'(error),     32'd0);
        check("reload_core_hold", 32'(core_hold), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"},        32'(imem_we),    32'd0);
        check({tag, "_addr"},      32'(imem_addr),  32'd0);
        check({tag, "_wdata"},     imem_wdata,      32'd0);
        check({tag, "_core_hold"}, 32'(core_hold),  32'd1);
        check({tag, "_done"},      32'(done),       32'd0);
        check({tag, "_error"},     32'(error),      32'd0);
        check({tag, "_rx_ready"},  32'(rx_ready),   32'd1);
    endtask

    initial begin
        logic [31:0] prog[$];
        logic [31:0] none[$];
        logic [31:0] rw[$];

        prog = '{32'h20080005, 32'h01094020};
        none = {};

        repeat (3) @(posedge clock);
        #1;
        check_reset_vals("reset");
        reset = 1'b0;

        // Good image: checksum 0x45.
        make_image(2, prog, 1'b0);
        check("csum_byte", 32'(img[img.size() - 1]), 32'h45);
        run_image(0, "good");
        pulse_reload();

        // Bad checksum, then a clean resend.
        make_image(2, prog, 1'b1);
        run_image(0, "badcs");
        pulse_reload();
        make_image(2, prog, 1'b0);
        run_image(0, "resend");
        pulse_reload();

        // Empty image.
        make_image(0, none, 1'b0);
        run_image(0, "empty");
        pulse_reload();

        // Oversized header: only the two count bytes are sent.
        img.delete();
        img.push_back(8'h01);
        img.push_back(8'h01);
        run_image(0, "toobig");
        pulse_reload();

        // Random stalls on the reference program.
        make_image(2, prog, 1'b0);
        run_image(50, "stall");
        pulse_reload();

        // Reset after three payload bytes.
        make_image(2, prog, 1'b0);
        clear_mon();
        send(0, 5);
        reset = 1'b1;
        #1;
        check_reset_vals("midreset");
        check("midreset_nwrites", 32'(wr_cyc_q.size()), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        run_image(0, "after_reset");
        pulse_reload();

        // Random images, random stalls, occasionally corrupted checksum.
        for (int k = 0; k < 4; k++) begin
            int n;
            n = $urandom_range(1, 8);
            rw.delete();
            for (int i = 0; i < n; i++) rw.push_back($urandom);
            make_image(n, rw, ($urandom_range(0, 3) == 0));
            run_image(30, "rand");
            pulse_reload();
        end

        // Full capacity: 2^DEPTH_W words is the largest accepted image.
        rw.delete();
        for (int i = 0; i < (1 << DW); i++) rw.push_back($urandom);
        make_image(1 << DW, rw, 1'b0);
        run_image(0, "full");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
